// File: rtl/lsu_dmem_ctrl_if.sv
// LSU-facing request/response bus and MMIO bus of the data-memory controller.
// Modport slave is the controller's view; master is the LSU plus MMIO-target view.
interface lsu_dmem_ctrl_if #(
  parameter int XLEN = 32
);
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ready;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_error;

  logic            mmio_req;
  logic            mmio_we;
  logic [XLEN-1:0] mmio_addr;
  logic [XLEN-1:0] mmio_wdata;
  logic            mmio_ack;
  logic [XLEN-1:0] mmio_rdata;

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mmio_ack, mmio_rdata,
    output mem_ready, mem_rdata, mem_error, mmio_req, mmio_we, mmio_addr, mmio_wdata
  );

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mmio_ack, mmio_rdata,
    input  mem_ready, mem_rdata, mem_error, mmio_req, mmio_we, mmio_addr, mmio_wdata
  );
endinterface

// File: rtl/lsu_dmem_ctrl.sv
// Data-memory controller behind the LSU: scratchpad SRAM, MMIO forwarding, error responses.
// Optional MMIO ack timeout is enabled by defining DMEM_MMIO_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for mem_req; latches and decodes the access
// SPAD  | scratchpad latency countdown, completes on terminal count
// MMIO  | mmio_req held until mmio_ack (or timeout when enabled)
// ERR   | misaligned/unmapped access, error response
// TURN  | response cleared; mem_req ignored while the LSU still holds it
module lsu_dmem_ctrl #(
  parameter int       XLEN         = 32,
  parameter int       SPAD_WORDS   = 1024,
  parameter int       SPAD_LAT     = 1,
  parameter logic [3:0] MMIO_REGION = 4'hF,
  parameter int       MMIO_TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  lsu_dmem_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(SPAD_WORDS);
  localparam int LAT_W = (SPAD_LAT > 1) ? $clog2(SPAD_LAT) : 1;
  localparam logic [XLEN:0] SPAD_BYTES = (XLEN+1)'(SPAD_WORDS) << 2;

  typedef enum logic [2:0] {IDLE, SPAD, MMIO, ERR, TURN} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic              we_q, we_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              mem_ready_q, mem_ready_d;
  logic [XLEN-1:0]   mem_rdata_q, mem_rdata_d;
  logic              mem_error_q, mem_error_d;
  logic              mmio_req_q, mmio_req_d;
  logic              mmio_we_q, mmio_we_d;
  logic [XLEN-1:0]   mmio_addr_q, mmio_addr_d;
  logic [XLEN-1:0]   mmio_wdata_q, mmio_wdata_d;
  logic              spad_we;
  logic [IDX_W-1:0]  spad_idx;
  logic [XLEN-1:0]   spad_mem [SPAD_WORDS];

`ifdef DMEM_MMIO_TIMEOUT_EN
  localparam int TMO_W = $clog2(MMIO_TIMEOUT + 1);
  logic [TMO_W-1:0]  tmo_q, tmo_d;
`endif

  assign spad_idx = addr_q[IDX_W+1:2];

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    lat_d        = lat_q;
    mem_ready_d  = 1'b0;
    mem_rdata_d  = '0;
    mem_error_d  = 1'b0;
    mmio_req_d   = mmio_req_q;
    mmio_we_d    = mmio_we_q;
    mmio_addr_d  = mmio_addr_q;
    mmio_wdata_d = mmio_wdata_q;
    spad_we      = 1'b0;
`ifdef DMEM_MMIO_TIMEOUT_EN
    tmo_d        = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.mem_req) begin
          addr_d  = bus.mem_addr;
          we_d    = bus.mem_we;
          wdata_d = bus.mem_wdata;
          lat_d   = LAT_W'(SPAD_LAT - 1);
`ifdef DMEM_MMIO_TIMEOUT_EN
          tmo_d   = TMO_W'(MMIO_TIMEOUT - 1);
`endif
          // Misalignment outranks region decode, so a misaligned MMIO address errors too.
          if (bus.mem_addr[1:0] != 2'b00)                   state_d = ERR;
          else if (bus.mem_addr[XLEN-1 -: 4] == MMIO_REGION) state_d = MMIO;
          else if ({1'b0, bus.mem_addr} < SPAD_BYTES)        state_d = SPAD;
          else                                               state_d = ERR;
        end
      end
      SPAD: begin
        if (lat_q == '0) begin
          mem_ready_d = 1'b1;
          state_d     = TURN;
          if (we_q) begin
            spad_we     = 1'b1;
            mem_rdata_d = wdata_q;
          end else begin
            mem_rdata_d = spad_mem[spad_idx];
          end
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      MMIO: begin
        // An ack only counts once the request is actually on the bus.
        if (mmio_req_q && bus.mmio_ack) begin
          mmio_req_d  = 1'b0;
          mem_ready_d = 1'b1;
          mem_rdata_d = we_q ? '0 : bus.mmio_rdata;
          state_d     = TURN;
        end else begin
          mmio_req_d   = 1'b1;
          mmio_we_d    = we_q;
          mmio_addr_d  = addr_q;
          mmio_wdata_d = wdata_q;
`ifdef DMEM_MMIO_TIMEOUT_EN
          if (tmo_q == '0) begin
            mmio_req_d  = 1'b0;
            mem_ready_d = 1'b1;
            mem_error_d = 1'b1;
            state_d     = TURN;
          end else begin
            tmo_d = tmo_q - 1'b1;
          end
`endif
        end
      end
      ERR: begin
        mem_ready_d = 1'b1;
        mem_error_d = 1'b1;
        state_d     = TURN;
      end
      TURN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      lat_q        <= '0;
      mem_ready_q  <= 1'b0;
      mem_rdata_q  <= '0;
      mem_error_q  <= 1'b0;
      mmio_req_q   <= 1'b0;
      mmio_we_q    <= 1'b0;
      mmio_addr_q  <= '0;
      mmio_wdata_q <= '0;
`ifdef DMEM_MMIO_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      lat_q        <= lat_d;
      mem_ready_q  <= mem_ready_d;
      mem_rdata_q  <= mem_rdata_d;
      mem_error_q  <= mem_error_d;
      mmio_req_q   <= mmio_req_d;
      mmio_we_q    <= mmio_we_d;
      mmio_addr_q  <= mmio_addr_d;
      mmio_wdata_q <= mmio_wdata_d;
`ifdef DMEM_MMIO_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  // Array is not reset; a reset landing on the commit edge drops the write.
  always_ff @(posedge clk) begin
    if (spad_we && !reset) begin
      spad_mem[spad_idx] <= wdata_q;
    end
  end

  assign bus.mem_ready  = mem_ready_q;
  assign bus.mem_rdata  = mem_rdata_q;
  assign bus.mem_error  = mem_error_q;
  assign bus.mmio_req   = mmio_req_q;
  assign bus.mmio_we    = mmio_we_q;
  assign bus.mmio_addr  = mmio_addr_q;
  assign bus.mmio_wdata = mmio_wdata_q;

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Scoreboard bench for lsu_dmem_ctrl: SPAD_LAT=1 instance for main traffic, SPAD_LAT=3 instance for reset abort.
module tb_lsu_dmem_ctrl;
  localparam int XLEN = 32;
  localparam int TMO  = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lsu_dmem_ctrl_if #(.XLEN(XLEN)) b  ();
  lsu_dmem_ctrl_if #(.XLEN(XLEN)) b3 ();

  lsu_dmem_ctrl #(.XLEN(XLEN), .SPAD_WORDS(1024), .SPAD_LAT(1), .MMIO_REGION(4'hF), .MMIO_TIMEOUT(TMO))
    u_dut (.clk(clk), .reset(reset), .bus(b));
  lsu_dmem_ctrl #(.XLEN(XLEN), .SPAD_WORDS(1024), .SPAD_LAT(3), .MMIO_REGION(4'hF), .MMIO_TIMEOUT(TMO))
    u_dut3 (.clk(clk), .reset(reset), .bus(b3));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  always @(negedge clk) begin
    exp_t e;
    if (!reset && b.mem_ready) begin
      chk("sb_pending", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("sb_rdata", b.mem_rdata, e.rdata);
        chk("sb_error", 32'(b.mem_error), 32'(e.err));
      end
    end
  end

  // MMIO target model: acks after ack_delay cycles of mmio_req (0 = never).
  int          ack_delay = 0;
  int          mm_cnt    = 0;
  logic        mmio_seen = 1'b0;
  logic        stray_ack = 1'b0;
  logic [31:0] exp_maddr = '0, exp_mwdata = '0, ack_rdata = '0;
  logic        exp_mwe   = 1'b0;

  always @(posedge clk) begin
    #1;
    if (b.mmio_req) begin
      mmio_seen = 1'b1;
      chk("mmio_addr", b.mmio_addr, exp_maddr);
      chk("mmio_we", 32'(b.mmio_we), 32'(exp_mwe));
      chk("mmio_wdata", b.mmio_wdata, exp_mwdata);
      mm_cnt++;
      if (ack_delay != 0 && mm_cnt == ack_delay) begin
        b.mmio_ack   = 1'b1;
        b.mmio_rdata = ack_rdata;
      end else begin
        b.mmio_ack   = 1'b0;
      end
    end else begin
      mm_cnt       = 0;
      b.mmio_ack   = stray_ack;
      b.mmio_rdata = 32'hBAD0BAD0;
    end
  end

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_cyc,
                        input logic keep, input string tag);
    int cyc = 0;
    exp_t e;
    e.rdata = exp_rd;
    e.err   = exp_err;
    sb_q.push_back(e);
    b.mem_we    = we;
    b.mem_addr  = addr;
    b.mem_wdata = wdata;
    b.mem_req   = 1'b1;
    while (cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (b.mem_ready) break;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'(exp_cyc));
    if (!keep) begin
      b.mem_req = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_turn_rdy"}, 32'(b.mem_ready), 32'd0);
      chk({tag, "_turn_rd"}, b.mem_rdata, 32'd0);
      chk({tag, "_turn_err"}, 32'(b.mem_error), 32'd0);
    end
  endtask

  task automatic acc3(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input int exp_cyc, input string tag);
    int cyc = 0;
    b3.mem_we    = we;
    b3.mem_addr  = addr;
    b3.mem_wdata = wdata;
    b3.mem_req   = 1'b1;
    while (cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
      if (b3.mem_ready) break;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_rd"}, b3.mem_rdata, exp_rd);
    chk({tag, "_err"}, 32'(b3.mem_error), 32'd0);
    b3.mem_req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    reset = 1'b1;
    b.mem_req = 1'b0;  b.mem_we = 1'b0;  b.mem_addr = '0;  b.mem_wdata = '0;
    b3.mem_req = 1'b0; b3.mem_we = 1'b0; b3.mem_addr = '0; b3.mem_wdata = '0;
    b3.mmio_ack = 1'b0; b3.mmio_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(b.mem_ready), 32'd0);
    chk("rst_rdata", b.mem_rdata, 32'd0);
    chk("rst_error", 32'(b.mem_error), 32'd0);
    chk("rst_mmio_req", 32'(b.mmio_req), 32'd0);
    chk("rst_mmio_we", 32'(b.mmio_we), 32'd0);
    chk("rst_mmio_addr", b.mmio_addr, 32'd0);
    chk("rst_mmio_wdata", b.mmio_wdata, 32'd0);
    chk("rst3_ready", 32'(b3.mem_ready), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Scratchpad, SPAD_LAT=1: 2 cycles from idle, 3 when mem_req is held through TURN.
    access(1'b1, 32'h8,   32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 2, 1'b0, "wr8");
    access(1'b0, 32'h8,   32'h0,        32'hDEADBEEF, 1'b0, 2, 1'b0, "rd8");
    access(1'b1, 32'h4,   32'hAAAA5555, 32'hAAAA5555, 1'b0, 2, 1'b1, "wr4");
    access(1'b0, 32'h4,   32'h0,        32'hAAAA5555, 1'b0, 3, 1'b0, "rd4_b2b");
    access(1'b1, 32'hFFC, 32'h13579BDF, 32'h13579BDF, 1'b0, 2, 1'b0, "wr_last");
    access(1'b0, 32'hFFC, 32'h0,        32'h13579BDF, 1'b0, 2, 1'b0, "rd_last");
    access(1'b0, 32'h8,   32'h0,        32'hDEADBEEF, 1'b0, 2, 1'b0, "rd8_again");
    access(1'b0, 32'h1000, 32'h0,       32'h0,        1'b1, 2, 1'b0, "rd_past_end");

    // Stray ack while idle must not produce a response.
    stray_ack = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("stray_ack_rdy", 32'(b.mem_ready), 32'd0);
    stray_ack = 1'b0;
    @(posedge clk); #1;

    // MMIO read then write.
    exp_maddr = 32'hF0000000; exp_mwe = 1'b0; exp_mwdata = 32'h0;
    ack_delay = 4; ack_rdata = 32'hCAFEF00D;
    access(1'b0, 32'hF0000000, 32'h0, 32'hCAFEF00D, 1'b0, 6, 1'b0, "mmio_rd");
    exp_maddr = 32'hF0000010; exp_mwe = 1'b1; exp_mwdata = 32'h5A5A0001;
    ack_delay = 1; ack_rdata = 32'h77777777;
    access(1'b1, 32'hF0000010, 32'h5A5A0001, 32'h0, 1'b0, 3, 1'b0, "mmio_wr");

    // Error paths: no array write, no MMIO request.
    mmio_seen = 1'b0;
    access(1'b1, 32'h6,        32'h99999999, 32'h0, 1'b1, 2, 1'b0, "misalign_wr");
    access(1'b0, 32'h4,        32'h0, 32'hAAAA5555, 1'b0, 2, 1'b0, "rd4_after_err");
    access(1'b0, 32'h00010000, 32'h0, 32'h0,        1'b1, 2, 1'b0, "unmapped_rd");
    access(1'b0, 32'hF0000002, 32'h0, 32'h0,        1'b1, 2, 1'b0, "misalign_mmio");
    chk("err_no_mmio", 32'(mmio_seen), 32'd0);

    // SPAD_LAT=3 instance: reset one cycle into a write aborts it.
    acc3(1'b1, 32'h0, 32'h12345678, 32'h12345678, 4, "l3_wr0");
    b3.mem_we = 1'b1; b3.mem_addr = 32'h0; b3.mem_wdata = 32'h11111111; b3.mem_req = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("l3_rst_ready", 32'(b3.mem_ready), 32'd0);
    chk("l3_rst_rdata", b3.mem_rdata, 32'd0);
    chk("l3_rst_error", 32'(b3.mem_error), 32'd0);
    chk("l3_rst_mmio", 32'(b3.mmio_req), 32'd0);
    reset = 1'b0;
    b3.mem_req = 1'b0;
    @(posedge clk); #1;
    acc3(1'b0, 32'h0, 32'h0, 32'h12345678, 4, "l3_rd0");

    // MMIO target that never acks.
    exp_maddr = 32'hF0000100; exp_mwe = 1'b0; exp_mwdata = 32'h0;
    ack_delay = 0;
`ifdef DMEM_MMIO_TIMEOUT_EN
    access(1'b0, 32'hF0000100, 32'h0, 32'h0, 1'b1, TMO + 1, 1'b1, "mmio_tmo");
    chk("mmio_tmo_req", 32'(b.mmio_req), 32'd0);
    b.mem_req = 1'b0;
    @(posedge clk); #1;
    chk("mmio_tmo_turn", 32'(b.mem_ready), 32'd0);
`else
    seen = 0;
    b.mem_we = 1'b0; b.mem_addr = 32'hF0000100; b.mem_wdata = 32'h0; b.mem_req = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (b.mem_ready) seen++;
    end
    chk("mmio_hang_rdy", 32'(seen), 32'd0);
    chk("mmio_hang_req", 32'(b.mmio_req), 32'd1);
    reset = 1'b1;
    b.mem_req = 1'b0;
    @(posedge clk); #1;
    chk("mmio_rst_req", 32'(b.mmio_req), 32'd0);
    chk("mmio_rst_addr", b.mmio_addr, 32'd0);
    chk("mmio_rst_rdy", 32'(b.mem_ready), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
`endif

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
